// File: rtl/lut_logic_arbiter_pkg.sv
// Shared opcode definitions for the LUT logic datapath.
// Used by the arbiter, the logic unit and their tests.
package lut_logic_arbiter_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_AND  = 2'b00;
    localparam logic [OP_W-1:0] OP_OR   = 2'b01;
    localparam logic [OP_W-1:0] OP_XOR  = 2'b10;
    localparam logic [OP_W-1:0] OP_NAND = 2'b11;

endpackage

// File: rtl/lut_logic_arbiter_unit.sv
// Combinational WIDTH-bit bitwise logic unit.
// One instance is shared by all requesters.
module lut_logic_unit
    import lut_logic_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);

    // Select the bitwise function named by the opcode
    always_comb begin
        o_y = '0;
        unique case (i_op)
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_NAND: o_y = ~(i_a & i_b);
        endcase
    end

endmodule

// File: rtl/lut_logic_arbiter.sv
// Round-robin arbiter sharing one LUT logic unit among N requesters.
// Result and owner id are registered; response appears one cycle after grant.
module lut_logic_arbiter
    import lut_logic_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N-1:0]       req_valid,
    input  logic [OP_W*N-1:0]  req_op,
    input  logic [WIDTH*N-1:0] req_a,
    input  logic [WIDTH*N-1:0] req_b,
    output logic [N-1:0]       req_ready,
    output logic [N-1:0]       rsp_valid,
    output logic [WIDTH-1:0]   rsp_y,
    output logic [15:0]        busy_cycles
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_rsp_id;
    logic             r_rsp_pending;
    logic [WIDTH-1:0] r_result;
    logic [15:0]      r_busy;

    logic [N-1:0]     w_grant;
    logic [PW-1:0]    w_gidx;
    logic [PW-1:0]    w_k;
    logic             w_found;
    logic [OP_W-1:0]  w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_y;
    logic [PW-1:0]    w_ptr_nxt;

    // Priority search starting at the pointer, wrapping modulo N
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int i = 0; i < N; i++) begin
            w_k = PW'((int'(r_ptr) + i) % N);
            if (!w_found && req_valid[w_k]) begin
                w_found      = 1'b1;
                w_gidx       = w_k;
                w_grant[w_k] = 1'b1;
            end
        end
    end

    assign w_op      = req_op[int'(w_gidx)*OP_W +: OP_W];
    assign w_a       = req_a[int'(w_gidx)*WIDTH +: WIDTH];
    assign w_b       = req_b[int'(w_gidx)*WIDTH +: WIDTH];
    assign w_ptr_nxt = PW'((int'(w_gidx) + 1) % N);

    lut_logic_unit #(
        .WIDTH (WIDTH)
    ) u_unit (
        .i_op (w_op),
        .i_a  (w_a),
        .i_b  (w_b),
        .o_y  (w_y)
    );

    // Accept the winner: advance pointer, capture result and owner, count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr         <= '0;
            r_rsp_id      <= '0;
            r_rsp_pending <= 1'b0;
            r_result      <= '0;
            r_busy        <= '0;
        end else begin
            r_rsp_pending <= w_found;
            if (w_found) begin
                r_ptr    <= w_ptr_nxt;
                r_rsp_id <= w_gidx;
                r_result <= w_y;
                if (r_busy != 16'hFFFF)
                    r_busy <= r_busy + 16'd1;
            end
        end
    end

    assign req_ready   = w_grant;
    assign rsp_valid   = r_rsp_pending ? (N'(1) << r_rsp_id) : '0;
    assign rsp_y       = r_result;
    assign busy_cycles = r_busy;

endmodule

// File: tb/tb_lut_logic_arbiter.sv
// Bench for lut_logic_arbiter: reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_lut_logic_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clock;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [2*N-1:0] req_op;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_y;
    logic [15:0]    busy_cycles;

    int checks = 0;
    int failures = 0;

    lut_logic_arbiter #(.N(N), .WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_y       (rsp_y),
        .busy_cycles (busy_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h",
                     name, $time, act, exp);
        end
    endtask

    // Reference model
    int     m_ptr = 0;
    bit     m_pend = 0;
    int     m_id = 0;
    int     m_y = 0;
    int     m_busy = 0;

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++)
            if (v[(p + i) % N] === 1'b1) return (p + i) % N;
        return -1;
    endfunction

    function automatic int op_eval(input int op, input int a, input int b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            default: return (~(a & b)) & 8'hFF;
        endcase
    endfunction

    always @(posedge clock or negedge reset) begin
        int g;
        if (!reset) begin
            m_ptr = 0; m_pend = 0; m_id = 0; m_y = 0; m_busy = 0;
        end else begin
            g = pick(req_valid, m_ptr);
            if (g >= 0) begin
                m_y = op_eval(int'(req_op[2*g +: 2]),
                              int'(req_a[W*g +: W]),
                              int'(req_b[W*g +: W]));
                m_id = g;
                m_pend = 1;
                m_ptr = (g + 1) % N;
                if (m_busy < 65535) m_busy++;
            end else begin
                m_pend = 0;
            end
        end
    end

    // Compare DUT to model once per cycle, away from the active edge
    always @(negedge clock) begin
        int g;
        g = pick(req_valid, m_ptr);
        check("m_req_ready", 32'(req_ready),
              g >= 0 ? 32'(1 << g) : 32'd0);
        check("m_rsp_valid", 32'(rsp_valid),
              m_pend ? 32'(1 << m_id) : 32'd0);
        check("m_rsp_y", 32'(rsp_y), 32'(m_y));
        check("m_busy", 32'(busy_cycles), 32'(m_busy));
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        req_op[2*i +: 2] = op;
        req_a[W*i +: W]  = a;
        req_b[W*i +: W]  = b;
    endtask

    initial begin
        reset = 1'b0;
        req_valid = '0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_y", 32'(rsp_y), 32'd0);
        check("rst_busy", 32'(busy_cycles), 32'd0);
        tick; tick;
        reset = 1'b1;

        // Single requester: OR 3|8
        set_req(0, 2'b01, 8'd3, 8'd8);
        req_valid = 4'b0001;
        #1 check("single_ready", 32'(req_ready), 32'h1);
        tick;
        check("single_rsp_valid", 32'(rsp_valid), 32'h1);
        check("single_rsp_y", 32'(rsp_y), 32'd11);
        check("single_busy", 32'(busy_cycles), 32'd1);
        req_valid = '0;

        // Opcode coverage on requester 2
        set_req(2, 2'b00, 8'hF0, 8'h3C);
        req_valid = 4'b0100;
        tick; check("op_and", 32'(rsp_y), 32'h30);
        req_op[5:4] = 2'b01;
        tick; check("op_or", 32'(rsp_y), 32'hFC);
        req_op[5:4] = 2'b10;
        tick; check("op_xor", 32'(rsp_y), 32'hCC);
        req_op[5:4] = 2'b11;
        tick; check("op_nand", 32'(rsp_y), 32'hCF);
        check("op_rsp_valid", 32'(rsp_valid), 32'h4);
        req_valid = '0;

        // Pointer wrap and skip: ptr=3, reqs 1 and 3
        set_req(1, 2'b10, 8'h11, 8'h22);
        set_req(3, 2'b00, 8'h0F, 8'hFF);
        req_valid = 4'b1010;
        #1 check("wrap_g0", 32'(req_ready), 32'h8);
        tick;
        check("wrap_g1", 32'(req_ready), 32'h2);
        check("wrap_r0", 32'(rsp_valid), 32'h8);
        tick;
        check("wrap_g2", 32'(req_ready), 32'h8);
        check("wrap_r1", 32'(rsp_valid), 32'h2);
        check("wrap_y1", 32'(rsp_y), 32'h33);
        tick;
        check("wrap_r2", 32'(rsp_valid), 32'h8);
        check("wrap_y2", 32'(rsp_y), 32'h0F);
        req_valid = '0;

        // Round robin with all four requesting for 8 cycles
        for (int i = 0; i < N; i++)
            set_req(i, 2'(i), 8'(8'h13 * (i + 1)), 8'(8'h5A + i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1 check("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            tick;
            check("rr_rsp", 32'(rsp_valid), 32'(1 << (k % 4)));
        end
        check("rr_busy", 32'(busy_cycles), 32'd16);
        req_valid = '0;

        // Idle gap: one grant, then nothing
        set_req(0, 2'b10, 8'h5A, 8'hFF);
        req_valid = 4'b0001;
        tick;
        check("idle_pulse", 32'(rsp_valid), 32'h1);
        check("idle_y", 32'(rsp_y), 32'hA5);
        req_valid = '0;
        tick;
        check("idle_off", 32'(rsp_valid), 32'h0);
        check("idle_hold", 32'(rsp_y), 32'hA5);
        tick;
        check("idle_off2", 32'(rsp_valid), 32'h0);
        req_valid = 4'b1111;
        #1 check("idle_ptr", 32'(req_ready), 32'h2);

        // Mid-operation reset
        tick;
        #2 reset = 1'b0;
        #1;
        check("mrst_valid", 32'(rsp_valid), 32'h0);
        check("mrst_y", 32'(rsp_y), 32'h0);
        check("mrst_busy", 32'(busy_cycles), 32'h0);
        check("mrst_ready", 32'(req_ready), 32'h1);
        tick; tick;
        reset = 1'b1;
        #1 check("post_ready", 32'(req_ready), 32'h1);
        tick;
        check("post_rsp", 32'(rsp_valid), 32'h1);
        check("post_busy", 32'(busy_cycles), 32'd1);
        req_valid = '0;
        tick; tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lut_logic_arbiter.md
# lut_logic_arbiter

Round-robin arbiter that shares one WIDTH-bit LUT logic unit (and/or/xor/nand) between N requesters. Accepts at most one operation per cycle, computes it, and returns the registered result to the winning requester one cycle later. Sits in front of the LUT logic datapath so several producers can use a single physical unit without duplicating LUTs.

## Interface
- N, default 4: number of requesters (2..8).
- WIDTH, default 8: operand and result width.
- clock  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  N  bit i: requester i has an operation pending.
- req_op  input  2*N  slice [2i+1:2i]: opcode of requester i.
- req_a  input  WIDTH*N  slice i: operand a of requester i.
- req_b  input  WIDTH*N  slice i: operand b of requester i.
- req_ready  output  N  one-hot (or zero) grant; request i is accepted when req_valid[i] and req_ready[i] are both high at a clock edge.
- rsp_valid  output  N  one-hot (or zero); bit i high means rsp_y holds requester i's result this cycle.
- rsp_y  output  WIDTH  result of the operation accepted on the previous cycle.
- busy_cycles  output  16  count of cycles in which a grant was issued; saturates at 16'hFFFF.

## Operation
- Opcodes: 2'b00 AND, 2'b01 OR, 2'b10 XOR, 2'b11 NAND. Bitwise over WIDTH bits, no carries.
- Arbitration is combinational from req_valid and the priority pointer ptr (log2 N bits).
  - Search order: ptr, ptr+1, …, ptr+N-1, wrapping modulo N.
  - The first requester with req_valid high receives req_ready.
  - At most one bit of req_ready is high. req_ready is zero when no request is valid.
- On an accepted request from requester g:
  - ptr <= (g+1) mod N.
  - result register <= op(a_g, b_g).
  - rsp_id register <= g.
  - rsp_pending <= 1.
- With no accepted request: ptr holds, and rsp_pending <= 0.
- Outputs:
  - rsp_valid = rsp_pending ? (1 << rsp_id) : 0.
  - rsp_y = result register. It holds its last value when rsp_pending is 0.
- Responses have no backpressure. Requesters must sample rsp_y in the cycle their rsp_valid bit is high.
- A requester may keep req_valid high across cycles. Each cycle it is granted counts as a new operation.
- busy_cycles increments on every cycle with a grant and stops at 16'hFFFF.
- Reset (reset low, any time, including mid-response) immediately forces:
  - ptr = 0, rsp_pending = 0, result = 0, rsp_id = 0, busy_cycles = 0.
  - Therefore rsp_valid = 0 and rsp_y = 0.
  - req_ready is still derived combinationally from req_valid with ptr = 0. Requests presented while reset is low are not accepted, because no state updates.

## Timing
- Grant-to-response latency: exactly 1 cycle. A request accepted at edge k has rsp_valid high between edge k and edge k+1.
- Throughput: 1 operation per cycle, sustained, across any mix of requesters.
- Back-to-back grants to different requesters give consecutive rsp_valid pulses, with one bit high per cycle.
- Fairness: with all N requesting continuously, each requester is granted exactly once every N cycles.
- Reset deassertion: the first grant can occur at the first rising edge after reset goes high.

## Structure
- Shared package / header: the opcode localparams (OP_AND, OP_OR, OP_XOR, OP_NAND) and the opcode width of 2. The LUT datapath and its tests reuse these.
- Sub-module lut_logic_unit: combinational WIDTH-bit op(a, b, op). It is instantiated once, fed by the multiplexed operands of the granted requester.
- The arbiter logic (pointer, priority search, grant mux), the response register and the counter all stay in lut_logic_arbiter.

## Test plan
- Single requester: N=4, WIDTH=8. Only req 0 is valid, op OR, a=3, b=8.
  - Expect req_ready=4'b0001.
  - Next cycle: rsp_valid=4'b0001, rsp_y=11.
  - busy_cycles=1.
- Opcode coverage: req 2 sends a=8'hF0, b=8'h3C with each opcode in turn.
  - Expect rsp_y of 30 (AND), FC (OR), CC (XOR), CF (NAND), all hex, one per cycle.
- Round robin: all 4 requesters valid continuously for 8 cycles.
  - Grant sequence is 0,1,2,3,0,1,2,3.
  - rsp_valid follows one cycle later.
  - busy_cycles=8.
- Pointer wrap and skip: ptr=3 (last grant was req 2), and only reqs 1 and 3 are valid.
  - Grant 3, then 1, then 3.
- Idle gap: a grant, then no valid requests.
  - rsp_valid pulses for exactly one cycle, then returns to 0.
  - rsp_y holds its value and ptr holds.
- Mid-operation reset: assert reset low in the cycle after a grant.
  - rsp_valid=0, rsp_y=0 and busy_cycles=0 immediately, without waiting for a clock edge.
  - After release, with all requesters valid, req 0 is granted first.
